// File: rtl/div_pkg.sv
// Shared definitions for the divider result display.
//   state_t      : FSM state encoding (IDLE / CONV / SHOW)
//   digit_idx_t  : scan position, 0 = rightmost digit (R units)
//   CODE_*       : internal 4-bit digit codes beyond 0..9
//   SEG_*        : active-low segment patterns {g,f,e,d,c,b,a}
//   dabble_step  : one shift-add-3 iteration on a two-digit BCD value
package div_pkg;

   typedef logic [1:0] state_t;
   localparam state_t IDLE = 2'd0;
   localparam state_t CONV = 2'd1;
   localparam state_t SHOW = 2'd2;

   typedef logic [1:0] digit_idx_t;
   localparam digit_idx_t DIG_R_UNITS = 2'd0;
   localparam digit_idx_t DIG_R_TENS  = 2'd1;
   localparam digit_idx_t DIG_Q_UNITS = 2'd2;
   localparam digit_idx_t DIG_Q_TENS  = 2'd3;

   localparam logic [3:0] CODE_R     = 4'hA;
   localparam logic [3:0] CODE_E     = 4'hE;
   localparam logic [3:0] CODE_BLANK = 4'hF;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_R     = 7'h2F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Correct any digit >= 5 by adding 3, then shift the next binary bit in.
   function automatic logic [7:0] dabble_step(input logic [7:0] bcd, input logic bit_in);
      logic [7:0] adj;
      adj = bcd;
      if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
      if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
      return {adj[6:0], bit_in};
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational digit-code to seven-segment decoder.
//   code : 0..9 digits, CODE_E, CODE_R, anything else is blank
//   seg  : active-low segments {g,f,e,d,c,b,a}
module seg7_decoder
   import div_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (code)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         CODE_E:  seg = SEG_E;
         CODE_R:  seg = SEG_R;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/div_result_display.sv
// Shows a 4-bit quotient and remainder as two decimal digits each on a
// multiplexed four-digit seven-segment display, or "Err " on divide by zero.
//   clk, rst      : clock, synchronous active-high reset
//   Q, R          : quotient / remainder to display
//   div_zero      : divisor was zero; show the error pattern instead
//   load, ready   : capture strobe, accepted while ready is high
//   An, Seg, Dp   : active-low anodes, segments {g,f,e,d,c,b,a}, decimal point
// Build option: DISP_LZ_BLANK_EN blanks a zero tens digit.
module div_result_display
   import div_pkg::*;
#(
   parameter int unsigned SCAN_BITS = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] Q,
   input  logic [3:0] R,
   input  logic       div_zero,
   input  logic       load,
   output logic       ready,
   output logic [3:0] An,
   output logic [6:0] Seg,
   output logic       Dp
);

   state_t                 state;
   logic [2:0]             step;
   logic [3:0]             q_sh, r_sh;
   logic [7:0]             q_bcd, r_bcd;
   logic                   err_cap;
   logic [7:0]             disp_q, disp_r;
   logic                   disp_err;
   logic                   shown;
   logic [SCAN_BITS-1:0]   scan;
   digit_idx_t             sel;
   logic                   active;
   logic [3:0]             code;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         step     <= '0;
         q_sh     <= '0;
         r_sh     <= '0;
         q_bcd    <= '0;
         r_bcd    <= '0;
         err_cap  <= 1'b0;
         disp_q   <= '0;
         disp_r   <= '0;
         disp_err <= 1'b0;
         shown    <= 1'b0;
         scan     <= '0;
      end else begin
         scan <= scan + SCAN_BITS'(1);
         case (state)
            IDLE, SHOW: begin
               if (load) begin
                  q_sh    <= Q;
                  r_sh    <= R;
                  err_cap <= div_zero;
                  q_bcd   <= '0;
                  r_bcd   <= '0;
                  step    <= '0;
                  state   <= CONV;
               end
            end
            CONV: begin
               // Four shift-add-3 iterations, then one edge to publish the
               // finished digits so the display never sees a partial value.
               if (step == 3'd4) begin
                  disp_q   <= q_bcd;
                  disp_r   <= r_bcd;
                  disp_err <= err_cap;
                  shown    <= 1'b1;
                  state    <= SHOW;
               end else begin
                  q_bcd <= dabble_step(q_bcd, q_sh[3]);
                  r_bcd <= dabble_step(r_bcd, r_sh[3]);
                  q_sh  <= {q_sh[2:0], 1'b0};
                  r_sh  <= {r_sh[2:0], 1'b0};
                  step  <= step + 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign ready  = (state != CONV);
   assign sel    = scan[SCAN_BITS-1 -: 2];
   // During a reload the previously published digits stay lit.
   assign active = shown && (state != IDLE);

   always_comb begin
      code = CODE_BLANK;
      if (active) begin
         if (disp_err) begin
            case (sel)
               DIG_Q_TENS:  code = CODE_E;
               DIG_Q_UNITS: code = CODE_R;
               DIG_R_TENS:  code = CODE_R;
               default:     code = CODE_BLANK;
            endcase
         end else begin
            case (sel)
               DIG_Q_TENS:  code = disp_q[7:4];
               DIG_Q_UNITS: code = disp_q[3:0];
               DIG_R_TENS:  code = disp_r[7:4];
               default:     code = disp_r[3:0];
            endcase
`ifdef DISP_LZ_BLANK_EN
            if ((sel == DIG_Q_TENS && disp_q[7:4] == 4'd0) ||
                (sel == DIG_R_TENS && disp_r[7:4] == 4'd0))
               code = CODE_BLANK;
`endif
         end
      end
   end

   seg7_decoder u_dec (
      .code (code),
      .seg  (Seg)
   );

   assign An = active ? ~(4'b0001 << sel) : 4'b1111;
   assign Dp = !(active && !disp_err && (sel == DIG_Q_UNITS));

endmodule

// File: tb/tb_div_result_display.sv
module tb_div_result_display;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] Q = '0;
   logic [3:0] R = '0;
   logic       div_zero = 1'b0;
   logic       load = 1'b0;
   logic       ready;
   logic [3:0] An;
   logic [6:0] Seg;
   logic       Dp;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   logic [6:0] seg_cap [4];
   logic       dp_cap  [4];
   logic [6:0] exp_seg [4];
   logic       exp_dp  [4];

`ifdef DISP_LZ_BLANK_EN
   localparam logic [6:0] TENS_ZERO = 7'h7F;
`else
   localparam logic [6:0] TENS_ZERO = 7'h40;
`endif

   div_result_display #(.SCAN_BITS(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .Q        (Q),
      .R        (R),
      .div_zero (div_zero),
      .load     (load),
      .ready    (ready),
      .An       (An),
      .Seg      (Seg),
      .Dp       (Dp)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Record the segments/dp seen for each anode over one full scan period.
   task automatic capture_digits();
      for (int j = 0; j < 4; j++) begin
         seg_cap[j] = 'x;
         dp_cap[j]  = 1'bx;
      end
      repeat (16) begin
         @(negedge clk);
         case (An)
            4'b1110: begin seg_cap[0] = Seg; dp_cap[0] = Dp; end
            4'b1101: begin seg_cap[1] = Seg; dp_cap[1] = Dp; end
            4'b1011: begin seg_cap[2] = Seg; dp_cap[2] = Dp; end
            4'b0111: begin seg_cap[3] = Seg; dp_cap[3] = Dp; end
            default: ;
         endcase
      end
   endtask

   // Drive a load (called #1 after a posedge); returns #1 after edge k.
   task automatic do_load(input logic [3:0] q, input logic [3:0] r, input logic dz);
      Q = q; R = r; div_zero = dz; load = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; load = 1'b1; Q = 4'd5; R = 4'd3;
      @(posedge clk); #1;
      n_vec++;
      if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready); end
      n_vec++;
      if (An !== 4'b1111) begin n_err++; $display("FAIL reset_an: got %b want 1111", An); end
      n_vec++;
      if (Seg !== 7'h7F) begin n_err++; $display("FAIL reset_seg: got %h want 7f", Seg); end
      n_vec++;
      if (Dp !== 1'b1) begin n_err++; $display("FAIL reset_dp: got %b want 1", Dp); end
      @(posedge clk); #1;
      rst = 1'b0; load = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (ready !== 1'b1 || An !== 4'b1111) begin
         n_err++; $display("FAIL reset_load_ignored: ready=%b An=%b want 1/1111", ready, An);
      end
   endtask

   task automatic test_basic();
      do_load(4'd5, 4'd3, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         n_vec++;
         if (ready !== 1'b0 || An !== 4'b1111) begin
            n_err++; $display("FAIL basic_conv_k%0d: ready=%b An=%b want 0/1111", i, ready, An);
         end
      end
      @(posedge clk); #1;
      n_vec++;
      if (ready !== 1'b1 || An === 4'b1111) begin
         n_err++; $display("FAIL basic_show_k5: ready=%b An=%b want 1/lit", ready, An);
      end
      capture_digits();
      exp_seg[3] = TENS_ZERO; exp_seg[2] = 7'h12; exp_seg[1] = TENS_ZERO; exp_seg[0] = 7'h30;
      exp_dp[3] = 1'b1; exp_dp[2] = 1'b0; exp_dp[1] = 1'b1; exp_dp[0] = 1'b1;
      for (int j = 0; j < 4; j++) begin
         n_vec++;
         if (seg_cap[j] !== exp_seg[j] || dp_cap[j] !== exp_dp[j]) begin
            n_err++;
            $display("FAIL basic_d%0d: seg=%h dp=%b want seg=%h dp=%b", j, seg_cap[j], dp_cap[j], exp_seg[j], exp_dp[j]);
         end
      end
   endtask

   task automatic test_tens();
      @(posedge clk); #1;
      do_load(4'd14, 4'd0, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      capture_digits();
      exp_seg[3] = 7'h79; exp_seg[2] = 7'h19; exp_seg[1] = TENS_ZERO; exp_seg[0] = 7'h40;
      for (int j = 0; j < 4; j++) begin
         n_vec++;
         if (seg_cap[j] !== exp_seg[j]) begin
            n_err++; $display("FAIL tens_d%0d: seg=%h want %h", j, seg_cap[j], exp_seg[j]);
         end
      end
   endtask

   task automatic test_div_zero();
      @(posedge clk); #1;
      do_load(4'd7, 4'd7, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      capture_digits();
      exp_seg[3] = 7'h06; exp_seg[2] = 7'h2F; exp_seg[1] = 7'h2F; exp_seg[0] = 7'h7F;
      for (int j = 0; j < 4; j++) begin
         n_vec++;
         if (seg_cap[j] !== exp_seg[j] || dp_cap[j] !== 1'b1) begin
            n_err++;
            $display("FAIL divzero_d%0d: seg=%h dp=%b want seg=%h dp=1", j, seg_cap[j], dp_cap[j], exp_seg[j]);
         end
      end
   endtask

   task automatic test_back_to_back();
      @(posedge clk); #1;
      do_load(4'd9, 4'd1, 1'b0);            // edge k
      @(posedge clk); #1;                   // k+1
      Q = 4'd2; R = 4'd2; load = 1'b1;
      @(posedge clk); #1;                   // k+2: ignored
      load = 1'b0;
      @(posedge clk); #1;                   // k+3
      @(posedge clk); #1;                   // k+4
      n_vec++;
      if (ready !== 1'b0) begin n_err++; $display("FAIL b2b_conv_k4: ready=%b want 0", ready); end
      @(posedge clk); #1;                   // k+5
      n_vec++;
      if (ready !== 1'b1) begin n_err++; $display("FAIL b2b_show_k5: ready=%b want 1", ready); end
      capture_digits();
      n_vec++;
      if (seg_cap[2] !== 7'h10 || seg_cap[0] !== 7'h79) begin
         n_err++; $display("FAIL b2b_first: d2=%h d0=%h want 10/79", seg_cap[2], seg_cap[0]);
      end
      @(posedge clk); #1;
      do_load(4'd2, 4'd2, 1'b0);
      n_vec++;
      if (ready !== 1'b0) begin n_err++; $display("FAIL b2b_reload_ready: ready=%b want 0", ready); end
      repeat (4) @(posedge clk);
      #1;
      n_vec++;
      if (ready !== 1'b0) begin n_err++; $display("FAIL b2b_reload_k4: ready=%b want 0", ready); end
      @(posedge clk); #1;
      n_vec++;
      if (ready !== 1'b1) begin n_err++; $display("FAIL b2b_reload_k5: ready=%b want 1", ready); end
      capture_digits();
      n_vec++;
      if (seg_cap[2] !== 7'h24 || seg_cap[0] !== 7'h24) begin
         n_err++; $display("FAIL b2b_second: d2=%h d0=%h want 24/24", seg_cap[2], seg_cap[0]);
      end
   endtask

   task automatic test_scan();
      logic [3:0] pat [4];
      logic [3:0] prev;
      logic [3:0] want;
      bit         found;
      pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b1011; pat[3] = 4'b0111;
      found = 1'b0;
      @(negedge clk);
      prev = An;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         if (An === 4'b1110 && prev !== 4'b1110) found = 1'b1;
         prev = An;
      end
      n_vec++;
      if (!found) begin
         n_err++; $display("FAIL scan_sync: no 1110 entry within 20 cycles, An=%b", An);
      end else begin
         for (int s = 1; s <= 16; s++) begin
            @(negedge clk);
            want = pat[(s / 4) % 4];
            n_vec++;
            if (An !== want) begin
               n_err++; $display("FAIL scan_step%0d: An=%b want %b", s, An, want);
            end
         end
      end
   endtask

   task automatic test_rst_in_conv();
      @(posedge clk); #1;
      do_load(4'd8, 4'd6, 1'b0);            // edge k
      @(posedge clk); #1;                   // k+1
      rst = 1'b1;
      @(posedge clk); #1;                   // k+2: reset
      rst = 1'b0;
      n_vec++;
      if (ready !== 1'b1 || An !== 4'b1111 || Seg !== 7'h7F) begin
         n_err++; $display("FAIL rstconv_idle: ready=%b An=%b Seg=%h want 1/1111/7f", ready, An, Seg);
      end
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         n_vec++;
         if (An !== 4'b1111) begin
            n_err++; $display("FAIL rstconv_dark%0d: An=%b want 1111", c, An);
         end
      end
   endtask

   initial begin
      @(posedge clk); #1;
      test_reset();
      test_basic();
      test_tens();
      test_div_zero();
      test_back_to_back();
      test_scan();
      test_rst_in_conv();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
